csr_unit: RTL and testbench

Machine-mode control-and-status register file for the single-cycle RV32I core. It sits directly downstream of the instruction decoder/controller and consumes its CSR read/write enables, CSR operation and address fields. It holds the machine CSRs and a 64-bit cycle counter, arbitrates external and timer interrupts at instruction boundaries, and supplies the PC-redirect target for traps and `mret`.

---
 rtl/csr_unit.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_csr_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit
//
// Machine-mode CSR file for the single-cycle RV32I core. Holds mstatus, mie,
// mtvec, mscratch, mepc, mcause, mip and the 64-bit mcycle counter, performs
// CSRRW/CSRRS/CSRRC read-modify-write, takes external/timer interrupts at
// instruction boundaries and supplies the PC redirect for traps and mret.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   instr_valid       current cycle holds a retiring instruction
//   csr_rd, csr_wr    CSR read / write enables from the controller
//   csr_op            01 RW, 10 RS, 11 RC, 00 no operation
//   csr_addr          12-bit CSR address
//   csr_wdata         rs1 value or zero-extended zimm
//   pc                PC of the current instruction
//   is_mret           current instruction is mret
//   ext_irq           level-sensitive external interrupt
//   timer_irq         level-sensitive timer interrupt
//   csr_rdata         old value of the addressed CSR (combinational)
//   illegal_csr       unimplemented / read-only CSR access (combinational)
//   redirect          PC must load redirect_pc this cycle (combinational)
//   redirect_pc       trap vector or mepc (combinational)
// ---------------------------------------------------------------------------
module csr_unit #(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic            csr_rd,
    input  logic            csr_wr,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] pc,
    input  logic            is_mret,
    input  logic            ext_irq,
    input  logic            timer_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal_csr,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] MTVEC_INIT    = MTVEC_RESET & ALIGN_MASK;
    localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;
    localparam logic [31:0] ALL_ONES      = 32'hFFFF_FFFF;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Read-modify-write result for the CSR instruction variants.
    function automatic logic [31:0] csr_modify(
        input logic [1:0]  op,
        input logic [31:0] old_val,
        input logic [31:0] wdata
    );
        logic [31:0] res;
        case (op)
            2'b01:   res = wdata;
            2'b10:   res = old_val | wdata;
            2'b11:   res = old_val & ~wdata;
            default: res = old_val;
        endcase
        return res;
    endfunction

    // True for every address this block implements.
    function automatic logic csr_implemented(input logic [11:0] addr);
        logic hit;
        case (addr)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MIP, ADDR_MCYCLE, ADDR_MCYCLEH: hit = 1'b1;
            default:                                          hit = 1'b0;
        endcase
        return hit;
    endfunction

    // mip is read-only here, and addr[11:10] == 11 is the read-only CSR space.
    function automatic logic csr_read_only(input logic [11:0] addr);
        return (addr == ADDR_MIP) || (addr[11:10] == 2'b11);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q,     mie_mtie_d;
    logic        mie_meie_q,     mie_meie_d;
    logic        mip_mtip_q,     mip_mtip_d;
    logic        mip_meip_q,     mip_meip_d;
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:0] mscratch_q,     mscratch_d;
    logic [31:0] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;
    logic [31:0] mcycle_q,       mcycle_d;
    logic [31:0] mcycleh_q,      mcycleh_d;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic        access_s;
    logic        illegal_s;
    logic [31:0] mstatus_val_s;
    logic [31:0] mie_val_s;
    logic [31:0] mip_val_s;
    logic [31:0] old_val_s;
    logic [31:0] new_val_s;
    logic        ext_pend_s;
    logic        tmr_pend_s;
    logic        trap_s;
    logic        mret_s;
    logic        wr_en_s;
    logic        wr_mstatus_s;
    logic        wr_mie_s;
    logic        wr_mtvec_s;
    logic        wr_mscratch_s;
    logic        wr_mepc_s;
    logic        wr_mcause_s;
    logic        wr_mcycle_s;
    logic        wr_mcycleh_s;
    logic        carry_s;

    // Architectural read views of the partially implemented registers.
    assign mstatus_val_s = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mie_val_s     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
    assign mip_val_s     = {20'b0, mip_meip_q, 3'b0, mip_mtip_q, 7'b0};

    // Access legality check.
    assign access_s  = csr_rd | csr_wr;
    assign illegal_s = access_s & (~csr_implemented(csr_addr)
                                   | (csr_wr & csr_read_only(csr_addr)));

    // Old-value multiplexer for the addressed CSR.
    always_comb begin
        old_val_s = 32'h0000_0000;
        case (csr_addr)
            ADDR_MSTATUS:  old_val_s = mstatus_val_s;
            ADDR_MIE:      old_val_s = mie_val_s;
            ADDR_MTVEC:    old_val_s = mtvec_q;
            ADDR_MSCRATCH: old_val_s = mscratch_q;
            ADDR_MEPC:     old_val_s = mepc_q;
            ADDR_MCAUSE:   old_val_s = mcause_q;
            ADDR_MIP:      old_val_s = mip_val_s;
            ADDR_MCYCLE:   old_val_s = mcycle_q;
            ADDR_MCYCLEH:  old_val_s = mcycleh_q;
            default:       old_val_s = 32'h0000_0000;
        endcase
    end

    assign new_val_s = csr_modify(csr_op, old_val_s, csr_wdata);

    // Interrupt arbitration; uses the registered mip copies, so an IRQ
    // line needs one edge before it can trap.
    assign ext_pend_s = mie_meie_q & mip_meip_q;
    assign tmr_pend_s = mie_mtie_q & mip_mtip_q;
    assign trap_s     = ~rst & instr_valid & mstatus_mie_q & (ext_pend_s | tmr_pend_s);
    assign mret_s     = ~rst & instr_valid & is_mret & ~trap_s;

    // A trap replaces the instruction, so its CSR write is dropped.
    assign wr_en_s       = ~rst & instr_valid & csr_wr & ~illegal_s & ~trap_s;
    assign wr_mstatus_s  = wr_en_s & (csr_addr == ADDR_MSTATUS);
    assign wr_mie_s      = wr_en_s & (csr_addr == ADDR_MIE);
    assign wr_mtvec_s    = wr_en_s & (csr_addr == ADDR_MTVEC);
    assign wr_mscratch_s = wr_en_s & (csr_addr == ADDR_MSCRATCH);
    assign wr_mepc_s     = wr_en_s & (csr_addr == ADDR_MEPC);
    assign wr_mcause_s   = wr_en_s & (csr_addr == ADDR_MCAUSE);
    assign wr_mcycle_s   = wr_en_s & (csr_addr == ADDR_MCYCLE);
    assign wr_mcycleh_s  = wr_en_s & (csr_addr == ADDR_MCYCLEH);

    // Writing the low half replaces its increment, so no carry leaves it.
    assign carry_s = (mcycle_q == ALL_ONES) & ~wr_mcycle_s;

    // Combinational outputs: read data, illegal flag and PC redirect.
    always_comb begin
        csr_rdata   = 32'h0000_0000;
        illegal_csr = 1'b0;
        redirect    = 1'b0;
        redirect_pc = mepc_q;
        if (csr_rd & ~illegal_s) begin
            csr_rdata = old_val_s;
        end else begin
            csr_rdata = 32'h0000_0000;
        end
        illegal_csr = ~rst & illegal_s;
        redirect    = trap_s | mret_s;
        if (trap_s) begin
            redirect_pc = mtvec_q;
        end else begin
            redirect_pc = mepc_q;
        end
    end

    // Next-state logic for mstatus: trap entry, then mret, then CSR write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        if (trap_s) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_s) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_mstatus_s) begin
            mstatus_mie_d  = new_val_s[3];
            mstatus_mpie_d = new_val_s[7];
        end else begin
            mstatus_mie_d  = mstatus_mie_q;
            mstatus_mpie_d = mstatus_mpie_q;
        end
    end

    // Next-state logic for the trap-capture registers mepc and mcause.
    always_comb begin
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (trap_s) begin
            mepc_d = pc & ALIGN_MASK;
            if (ext_pend_s) begin
                mcause_d = CAUSE_EXT;
            end else begin
                mcause_d = CAUSE_TIMER;
            end
        end else begin
            if (wr_mepc_s) begin
                mepc_d = new_val_s & ALIGN_MASK;
            end else begin
                mepc_d = mepc_q;
            end
            if (wr_mcause_s) begin
                mcause_d = new_val_s;
            end else begin
                mcause_d = mcause_q;
            end
        end
    end

    // Next-state logic for the plain software-written registers and mip.
    always_comb begin
        mie_mtie_d = wr_mie_s      ? new_val_s[7]             : mie_mtie_q;
        mie_meie_d = wr_mie_s      ? new_val_s[11]            : mie_meie_q;
        mtvec_d    = wr_mtvec_s    ? (new_val_s & ALIGN_MASK) : mtvec_q;
        mscratch_d = wr_mscratch_s ? new_val_s                : mscratch_q;
        mip_mtip_d = timer_irq;
        mip_meip_d = ext_irq;
    end

    // Next-state logic for the 64-bit cycle counter.
    always_comb begin
        if (wr_mcycle_s) begin
            mcycle_d = new_val_s;
        end else begin
            mcycle_d = mcycle_q + 32'd1;
        end
        if (wr_mcycleh_s) begin
            mcycleh_d = new_val_s;
        end else begin
            mcycleh_d = mcycleh_q + {31'b0, carry_s};
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mtvec_q        <= MTVEC_INIT;
            mscratch_q     <= 32'h0000_0000;
            mepc_q         <= 32'h0000_0000;
            mcause_q       <= 32'h0000_0000;
            mcycle_q       <= 32'h0000_0000;
            mcycleh_q      <= 32'h0000_0000;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mip_mtip_q     <= mip_mtip_d;
            mip_meip_q     <= mip_meip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            mcycleh_q      <= mcycleh_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit
//
// Directed, table-driven bench for csr_unit. Each record is one clock cycle:
// inputs are driven just after the rising edge, the combinational outputs
// are compared on the falling edge, and the rising edge commits state.
// State is observed only through CSR reads in later records.
// ---------------------------------------------------------------------------
module tb_csr_unit;

    typedef struct {
        string       name;
        logic        valid;
        logic        rd;
        logic        wr;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] pcv;
        logic        mret;
        logic        ext;
        logic        tmr;
        logic [31:0] exp_rdata;
        logic        exp_ill;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        csr_rd;
    logic        csr_wr;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] pc;
    logic        is_mret;
    logic        ext_irq;
    logic        timer_irq;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs[$];

    csr_unit #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0203)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .csr_rd      (csr_rd),
        .csr_wr      (csr_wr),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .pc          (pc),
        .is_mret     (is_mret),
        .ext_irq     (ext_irq),
        .timer_irq   (timer_irq),
        .csr_rdata   (csr_rdata),
        .illegal_csr (illegal_csr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic v, logic rd, logic wr, logic [1:0] op,
                                logic [11:0] a, logic [31:0] wd, logic [31:0] pcv,
                                logic mr, logic e, logic t, logic [31:0] erd,
                                logic eill, logic erdr, logic [31:0] erpc);
        vec_t r;
        r.name = nm;   r.valid = v;  r.rd = rd;     r.wr = wr;   r.op = op;
        r.addr = a;    r.wdata = wd; r.pcv = pcv;   r.mret = mr; r.ext = e;
        r.tmr = t;     r.exp_rdata = erd;           r.exp_ill = eill;
        r.exp_redir = erdr;          r.exp_rpc = erpc;
        return r;
    endfunction

    // Plain CSR read, no events.
    function automatic vec_t rdv(string nm, logic [11:0] a, logic [31:0] erd);
        return mk(nm, 1'b1, 1'b1, 1'b0, 2'b00, a, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                  erd, 1'b0, 1'b0, 32'h0);
    endfunction

    // CSR write (optionally also reading), no events.
    function automatic vec_t wv(string nm, logic rd, logic [1:0] op, logic [11:0] a,
                                logic [31:0] wd, logic [31:0] erd, logic eill);
        return mk(nm, 1'b1, rd, 1'b1, op, a, wd, 32'h0, 1'b0, 1'b0, 1'b0,
                  erd, eill, 1'b0, 32'h0);
    endfunction

    // Non-CSR instruction with interrupt / mret activity.
    function automatic vec_t ev(string nm, logic v, logic [31:0] pcv, logic mr, logic e,
                                logic t, logic erdr, logic [31:0] erpc);
        return mk(nm, v, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, pcv, mr, e, t,
                  32'h0, 1'b0, erdr, erpc);
    endfunction

    task automatic cmp(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: actual %h required %h", nm, field, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_valid = v.valid;
        csr_rd      = v.rd;
        csr_wr      = v.wr;
        csr_op      = v.op;
        csr_addr    = v.addr;
        csr_wdata   = v.wdata;
        pc          = v.pcv;
        is_mret     = v.mret;
        ext_irq     = v.ext;
        timer_irq   = v.tmr;
    endtask

    task automatic check(input vec_t v);
        cmp(v.name, "rdata",    csr_rdata,             v.exp_rdata);
        cmp(v.name, "illegal",  {31'b0, illegal_csr},  {31'b0, v.exp_ill});
        cmp(v.name, "redirect", {31'b0, redirect},     {31'b0, v.exp_redir});
        if (v.exp_redir) begin
            cmp(v.name, "redirect_pc", redirect_pc, v.exp_rpc);
        end
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        @(negedge clk);
        check(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(ev("idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

        // ---------------- main vector table ----------------
        vecs.push_back(rdv("rst_mstatus",  12'h300, 32'h0000_1800));
        vecs.push_back(rdv("rst_mie",      12'h304, 32'h0000_0000));
        vecs.push_back(rdv("rst_mtvec",    12'h305, 32'h0000_0200));
        vecs.push_back(rdv("rst_mscratch", 12'h340, 32'h0000_0000));
        vecs.push_back(rdv("rst_mepc",     12'h341, 32'h0000_0000));
        vecs.push_back(rdv("rst_mcause",   12'h342, 32'h0000_0000));
        vecs.push_back(rdv("rst_mip",      12'h344, 32'h0000_0000));
        vecs.push_back(wv("rw_scratch", 1'b1, 2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0));
        vecs.push_back(wv("rs_scratch", 1'b1, 2'b10, 12'h340, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0));
        vecs.push_back(rdv("scratch_set", 12'h340, 32'hDEAD_BEFF));
        vecs.push_back(wv("rc_scratch", 1'b1, 2'b11, 12'h340, 32'h0000_00F0, 32'hDEAD_BEFF, 1'b0));
        vecs.push_back(rdv("scratch_clr", 12'h340, 32'hDEAD_BE0F));
        vecs.push_back(wv("wr_mtvec", 1'b1, 2'b01, 12'h305, 32'h0000_0103, 32'h0000_0200, 1'b0));
        vecs.push_back(rdv("mtvec_align", 12'h305, 32'h0000_0100));
        vecs.push_back(wv("ill_mip_wr", 1'b1, 2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1));
        vecs.push_back(rdv("mip_kept", 12'h344, 32'h0000_0000));
        vecs.push_back(mk("ill_unimpl_rd", 1'b1, 1'b1, 1'b0, 2'b00, 12'hC00, 32'h0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0));
        vecs.push_back(wv("ill_ro_wr", 1'b0, 2'b01, 12'hF11, 32'h0000_0005, 32'h0000_0000, 1'b1));
        vecs.push_back(mk("no_access", 1'b1, 1'b0, 1'b0, 2'b00, 12'h7C0, 32'h0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(wv("wr_mepc_nord", 1'b0, 2'b01, 12'h341, 32'h0000_1237, 32'h0000_0000, 1'b0));
        vecs.push_back(rdv("mepc_align", 12'h341, 32'h0000_1234));
        vecs.push_back(mk("wr_invalid", 1'b0, 1'b1, 1'b1, 2'b01, 12'h340, 32'h0000_1111, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'hDEAD_BE0F, 1'b0, 1'b0, 32'h0));
        vecs.push_back(rdv("scratch_held", 12'h340, 32'hDEAD_BE0F));
        vecs.push_back(wv("wr_mie_all", 1'b1, 2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0));
        vecs.push_back(rdv("mie_mask", 12'h304, 32'h0000_0880));
        vecs.push_back(wv("wr_mie_ext", 1'b1, 2'b01, 12'h304, 32'h0000_0800, 32'h0000_0880, 1'b0));
        vecs.push_back(wv("wr_mstatus", 1'b1, 2'b01, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0));
        vecs.push_back(rdv("mstatus_mie", 12'h300, 32'h0000_1808));
        // external interrupt pulse, trap one cycle later
        vecs.push_back(ev("ext_pulse", 1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        vecs.push_back(ev("ext_trap",  1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100));
        vecs.push_back(rdv("trap_mepc",    12'h341, 32'h0000_0040));
        vecs.push_back(rdv("trap_mcause",  12'h342, 32'h8000_000B));
        vecs.push_back(rdv("trap_mstatus", 12'h300, 32'h0000_1880));
        vecs.push_back(rdv("mip_clear",    12'h344, 32'h0000_0000));
        vecs.push_back(ev("mret", 1'b1, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040));
        vecs.push_back(rdv("mret_mstatus", 12'h300, 32'h0000_1888));
        // both interrupts, trap collides with a CSR write
        vecs.push_back(wv("wr_mie_both", 1'b1, 2'b01, 12'h304, 32'h0000_0880, 32'h0000_0800, 1'b0));
        vecs.push_back(ev("both_irq", 1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk("trap_vs_wr", 1'b1, 1'b1, 1'b1, 2'b01, 12'h340, 32'h5555_5555,
                          32'h0000_0084, 1'b0, 1'b0, 1'b0, 32'hDEAD_BE0F, 1'b0, 1'b1, 32'h0000_0100));
        vecs.push_back(rdv("scratch_keep", 12'h340, 32'hDEAD_BE0F));
        vecs.push_back(rdv("prio_mcause",  12'h342, 32'h8000_000B));
        vecs.push_back(rdv("prio_mepc",    12'h341, 32'h0000_0084));
        // timer-only trap
        vecs.push_back(ev("mret2",     1'b1, 32'h0000_0088, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0084));
        vecs.push_back(ev("tmr_pulse", 1'b1, 32'h0000_008C, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
        vecs.push_back(ev("tmr_trap",  1'b1, 32'h0000_0090, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100));
        vecs.push_back(rdv("tmr_mcause", 12'h342, 32'h8000_0007));
        vecs.push_back(rdv("tmr_mepc",   12'h341, 32'h0000_0090));
        // trap together with mret
        vecs.push_back(ev("mret_tmr",     1'b1, 32'h0000_0094, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0090));
        vecs.push_back(ev("trap_vs_mret", 1'b1, 32'h0000_00A0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100));
        vecs.push_back(rdv("tm_mepc",    12'h341, 32'h0000_00A0));
        vecs.push_back(rdv("tm_mstatus", 12'h300, 32'h0000_1880));
        // level-sensitive line dropped before MIE is set: no trap
        vecs.push_back(ev("ext_no_mie", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        vecs.push_back(wv("set_mie_late", 1'b1, 2'b10, 12'h300, 32'h0000_0008, 32'h0000_1880, 1'b0));
        vecs.push_back(rdv("level_no_trap", 12'h300, 32'h0000_1888));
        // pending interrupt while no instruction retires: no trap
        vecs.push_back(ev("irq_inval_a", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        vecs.push_back(ev("irq_inval_b", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(rdv("no_trap_mstatus", 12'h300, 32'h0000_1888));

        // ---------------- reset phase ----------------
        repeat (2) @(posedge clk);
        #1;
        apply(mk("in_reset", 1'b1, 1'b0, 1'b1, 2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0,
                 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // ---------------- cycle counter corner cases ----------------
        apply(wv("wr_mcycleh",  1'b0, 2'b01, 12'hB80, 32'h0000_0000, 32'h0, 1'b0));
        apply(wv("wr_mcycle",   1'b0, 2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0));
        apply(wv("cyc_lo_max",  1'b1, 2'b01, 12'hB00, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0));
        apply(rdv("cyc_hi_nocarry", 12'hB80, 32'h0000_0000));
        apply(rdv("cyc_lo_count",   12'hB00, 32'h0000_0011));
        apply(wv("wr_mcycle2",  1'b0, 2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0));
        apply(rdv("cyc_lo_full", 12'hB00, 32'hFFFF_FFFF));
        apply(rdv("cyc_hi_wrap", 12'hB80, 32'h0000_0001));
        apply(rdv("cyc_lo_one",  12'hB00, 32'h0000_0001));

        // ---------------- reset asserted mid-operation ----------------
        drive(mk("rst_async", 1'b1, 1'b0, 1'b1, 2'b01, 12'h340, 32'h1234_5678, 32'h0,
                 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
        #2;
        rst = 1'b1;
        @(negedge clk);
        check(mk("rst_async", 1'b1, 1'b0, 1'b1, 2'b01, 12'h340, 32'h1234_5678, 32'h0,
                 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        apply(mk("rst_hold", 1'b1, 1'b0, 1'b1, 2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0,
                 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0));
        rst = 1'b0;
        apply(rdv("post_rst_lo0",     12'hB00, 32'h0000_0000));
        apply(rdv("post_rst_lo1",     12'hB00, 32'h0000_0001));
        apply(rdv("post_rst_hi",      12'hB80, 32'h0000_0000));
        apply(rdv("post_rst_scratch", 12'h340, 32'h0000_0000));
        apply(rdv("post_rst_mstatus", 12'h300, 32'h0000_1800));
        apply(rdv("post_rst_mip",     12'h344, 32'h0000_0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
